poly_voice_alloc: RTL and testbench

POLY_VOICE_ALLOC -- requirements
Module: poly_voice_alloc

---
 rtl/synth_pkg.sv | 12 +
 rtl/poly_voice_alloc_voice_slot.sv | 79 +++++++
 rtl/poly_voice_alloc.sv | 171 +++++++++++++++++
 tb/tb_poly_voice_alloc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// synth_pkg: shared defaults, allocator FSM states and a clog2 helper.
package synth_pkg;
    localparam int NOTE_W_DEF = 7;
    localparam int VEL_W_DEF = 7;
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/poly_voice_alloc_voice_slot.sv
// voice_slot: one voice's gate, note, velocity, age and sustain registers.
module voice_slot #(
    parameter int NOTE_W = 7,
    parameter int VEL_W = 7,
    parameter int AGE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              rel,
    input  logic              load,
    input  logic              age_up,
    input  logic              off,
    input  logic              off_sus,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [VEL_W-1:0]  vel_in,
    output logic              gate,
    output logic              sus,
    output logic              gate_nxt,
    output logic [NOTE_W-1:0] note,
    output logic [VEL_W-1:0]  vel,
    output logic [AGE_W-1:0]  age
);
    logic              gate_q, gate_d, sus_q, sus_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [VEL_W-1:0]  vel_q, vel_d;
    logic [AGE_W-1:0]  age_q, age_d;

    always_comb begin
        gate_d = gate_q;
        sus_d = sus_q;
        note_d = note_q;
        vel_d = vel_q;
        age_d = age_q;
        if (clr) begin
            gate_d = 1'b0;
            sus_d = 1'b0;
            age_d = '0;
        end else if (rel && sus_q) begin
            gate_d = 1'b0;
            sus_d = 1'b0;
        end else if (load) begin
            gate_d = 1'b1;
            sus_d = 1'b0;
            note_d = note_in;
            vel_d = vel_in;
            age_d = '0;
        end else if (off) begin
            // a held pedal keeps the gate open and marks the voice sustained
            gate_d = off_sus;
            sus_d = off_sus;
        end else if (age_up && gate_q && age_q != '1) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_q <= 1'b0;
            sus_q <= 1'b0;
            note_q <= '0;
            vel_q <= '0;
            age_q <= '0;
        end else begin
            gate_q <= gate_d;
            sus_q <= sus_d;
            note_q <= note_d;
            vel_q <= vel_d;
            age_q <= age_d;
        end
    end

    assign gate = gate_q;
    assign sus = sus_q;
    assign gate_nxt = gate_d;
    assign note = note_q;
    assign vel = vel_q;
    assign age = age_q;
endmodule

// File: rtl/poly_voice_alloc.sv
// poly_voice_alloc: polyphonic voice allocator; each event scans all voices
// one per cycle, then commits a retrigger/free/steal or note-off decision.
module poly_voice_alloc
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int VEL_W = VEL_W_DEF
) (
    input  logic                             CLK_50MHZ,
    input  logic                             RESET,
    input  logic                             inEventValid,
    output logic                             inEventReady,
    input  logic                             inNoteOn,
    input  logic [NOTE_W-1:0]                inNote,
    input  logic [VEL_W-1:0]                 inVelocity,
    input  logic                             inSustain,
    input  logic                             inAllNotesOff,
    output logic [NUM_VOICES-1:0]            outGate,
    output logic [NUM_VOICES*NOTE_W-1:0]     outNote,
    output logic [NUM_VOICES*VEL_W-1:0]      outVelocity,
    output logic                             outStealPulse,
    output logic [clog2(NUM_VOICES+1)-1:0]   outActiveCount
);
    localparam int IDX_W = clog2(NUM_VOICES);
    localparam int CNT_W = clog2(NUM_VOICES + 1);

    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, ret_i_q, ret_i_d, free_i_q, free_i_d;
    logic [IDX_W-1:0] off_i_q, off_i_d, old_i_q, old_i_d, tgt;
    logic [IDX_W-1:0] old_a_q, old_a_d;
    logic ret_f_q, ret_f_d, free_f_q, free_f_d, off_f_q, off_f_d;
    logic ev_on_q, ev_on_d, pend_q, pend_d, sus_prev_q, sus_prev_d, steal_q, steal_d;
    logic [NOTE_W-1:0] ev_note_q, ev_note_d;
    logic [VEL_W-1:0] ev_vel_q, ev_vel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic accept, panic, sus_fall, commit;
    logic [NUM_VOICES-1:0] gate, gate_nxt, sus, load, off;
    logic [NOTE_W-1:0] note_v [NUM_VOICES];
    logic [VEL_W-1:0] vel_v [NUM_VOICES];
    logic [IDX_W-1:0] age_v [NUM_VOICES];

    assign panic = (state_q == S_IDLE) && (inAllNotesOff || pend_q);
    assign sus_fall = (state_q == S_IDLE) && sus_prev_q && !inSustain;
    assign accept = inEventValid && inEventReady;
    assign commit = (state_q == S_COMMIT);

    always_ff @(posedge CLK_50MHZ) begin
        state_q <= RESET ? S_IDLE : state_d;
    end

    always_comb begin
        state_d = (state_q == S_IDLE) ? (accept ? S_SCAN : S_IDLE) :
                  (state_q == S_SCAN) ? ((idx_q == IDX_W'(NUM_VOICES - 1)) ? S_COMMIT : S_SCAN) :
                  S_IDLE;
    end

    always_comb begin
        inEventReady = (state_q == S_IDLE) && !RESET && !panic && !sus_fall;
    end

    always_comb begin
        idx_d = (state_q == S_SCAN) ? idx_q + 1'b1 : '0;
        ev_on_d = ev_on_q;
        ev_note_d = ev_note_q;
        ev_vel_d = ev_vel_q;
        ret_f_d = ret_f_q;
        ret_i_d = ret_i_q;
        free_f_d = free_f_q;
        free_i_d = free_i_q;
        off_f_d = off_f_q;
        off_i_d = off_i_q;
        old_a_d = old_a_q;
        old_i_d = old_i_q;
        if (accept) begin
            ev_on_d = inNoteOn && (inVelocity != '0);
            ev_note_d = inNote;
            ev_vel_d = inVelocity;
            ret_f_d = 1'b0;
            free_f_d = 1'b0;
            off_f_d = 1'b0;
            old_a_d = '0;
            old_i_d = '0;
        end
        if (state_q == S_SCAN) begin
            if (!ret_f_q && gate[idx_q] && note_v[idx_q] == ev_note_q) begin
                ret_f_d = 1'b1;
                ret_i_d = idx_q;
            end
            if (!free_f_q && !gate[idx_q]) begin
                free_f_d = 1'b1;
                free_i_d = idx_q;
            end
            if (!off_f_q && gate[idx_q] && !sus[idx_q] && note_v[idx_q] == ev_note_q) begin
                off_f_d = 1'b1;
                off_i_d = idx_q;
            end
            if (age_v[idx_q] > old_a_q) begin
                old_a_d = age_v[idx_q];
                old_i_d = idx_q;
            end
        end
        pend_d = (state_q == S_IDLE) ? 1'b0 : (pend_q || inAllNotesOff);
        sus_prev_d = (state_q == S_IDLE) ? inSustain : sus_prev_q;
        tgt = ret_f_q ? ret_i_q : free_f_q ? free_i_q : old_i_q;
        steal_d = commit && ev_on_q && !ret_f_q && !free_f_q;
        cnt_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) cnt_d = cnt_d + CNT_W'(gate_nxt[i]);
    end

    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            load[i] = commit && ev_on_q && (tgt == IDX_W'(i));
            off[i] = commit && !ev_on_q && off_f_q && (off_i_q == IDX_W'(i));
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RESET) begin
            idx_q <= '0;
            ev_on_q <= 1'b0;
            ev_note_q <= '0;
            ev_vel_q <= '0;
            ret_f_q <= 1'b0;
            ret_i_q <= '0;
            free_f_q <= 1'b0;
            free_i_q <= '0;
            off_f_q <= 1'b0;
            off_i_q <= '0;
            old_a_q <= '0;
            old_i_q <= '0;
            pend_q <= 1'b0;
            sus_prev_q <= 1'b0;
            steal_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            ev_on_q <= ev_on_d;
            ev_note_q <= ev_note_d;
            ev_vel_q <= ev_vel_d;
            ret_f_q <= ret_f_d;
            ret_i_q <= ret_i_d;
            free_f_q <= free_f_d;
            free_i_q <= free_i_d;
            off_f_q <= off_f_d;
            off_i_q <= off_i_d;
            old_a_q <= old_a_d;
            old_i_q <= old_i_d;
            pend_q <= pend_d;
            sus_prev_q <= sus_prev_d;
            steal_q <= steal_d;
            cnt_q <= cnt_d;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_slot #(.NOTE_W(NOTE_W), .VEL_W(VEL_W), .AGE_W(IDX_W)) u_slot (
            .clk(CLK_50MHZ), .rst(RESET), .clr(panic), .rel(sus_fall),
            .load(load[v]), .age_up(commit && ev_on_q), .off(off[v]), .off_sus(inSustain),
            .note_in(ev_note_q), .vel_in(ev_vel_q),
            .gate(gate[v]), .sus(sus[v]), .gate_nxt(gate_nxt[v]),
            .note(note_v[v]), .vel(vel_v[v]), .age(age_v[v])
        );
        assign outNote[v*NOTE_W +: NOTE_W] = note_v[v];
        assign outVelocity[v*VEL_W +: VEL_W] = vel_v[v];
    end

    assign outGate = gate;
    assign outStealPulse = steal_q;
    assign outActiveCount = cnt_q;
endmodule

// File: tb/tb_poly_voice_alloc.sv
// tb_poly_voice_alloc: directed and random events against an array-based voice model.
module tb_poly_voice_alloc;
    localparam int NV = 4;
    localparam int NW = 7;
    localparam int VW = 7;
    localparam int AMAX = 3;

    logic clk = 1'b0;
    logic rst, ev_valid, ev_ready, ev_on, sustain, all_off, steal;
    logic [NW-1:0] ev_note;
    logic [VW-1:0] ev_vel;
    logic [NV-1:0] gate;
    logic [NV*NW-1:0] notes;
    logic [NV*VW-1:0] vels;
    logic [2:0] count;

    int checks = 0;
    int failures = 0;
    bit m_gate [NV];
    bit m_sus [NV];
    int m_note [NV];
    int m_vel [NV];
    int m_age [NV];
    bit m_steal;

    always #5 clk = ~clk;

    poly_voice_alloc #(.NUM_VOICES(NV), .NOTE_W(NW), .VEL_W(VW)) dut (
        .CLK_50MHZ(clk), .RESET(rst), .inEventValid(ev_valid), .inEventReady(ev_ready),
        .inNoteOn(ev_on), .inNote(ev_note), .inVelocity(ev_vel), .inSustain(sustain),
        .inAllNotesOff(all_off), .outGate(gate), .outNote(notes), .outVelocity(vels),
        .outStealPulse(steal), .outActiveCount(count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] e_gate();
        logic [63:0] r = '0;
        for (int i = 0; i < NV; i++) r[i] = m_gate[i];
        return r;
    endfunction

    function automatic logic [63:0] e_note();
        logic [63:0] r = '0;
        for (int i = 0; i < NV; i++) r[i*NW +: NW] = NW'(m_note[i]);
        return r;
    endfunction

    function automatic logic [63:0] e_vel();
        logic [63:0] r = '0;
        for (int i = 0; i < NV; i++) r[i*VW +: VW] = VW'(m_vel[i]);
        return r;
    endfunction

    function automatic logic [63:0] e_cnt();
        int c = 0;
        for (int i = 0; i < NV; i++) c += int'(m_gate[i]);
        return 64'(c);
    endfunction

    task automatic check_all(input string tag);
        check({tag, ":gate"}, 64'(gate), e_gate());
        check({tag, ":note"}, 64'(notes), e_note());
        check({tag, ":vel"}, 64'(vels), e_vel());
        check({tag, ":count"}, 64'(count), e_cnt());
        check({tag, ":steal"}, 64'(steal), 64'(m_steal));
    endtask

    task automatic m_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_sus[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_age[i] = 0;
        end
        m_steal = 0;
    endtask

    task automatic m_panic();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0; m_sus[i] = 0; m_age[i] = 0;
        end
    endtask

    task automatic m_release();
        for (int i = 0; i < NV; i++) if (m_sus[i]) begin
            m_gate[i] = 0; m_sus[i] = 0;
        end
    endtask

    task automatic m_event(input bit on, input int n, input int v);
        int t = -1;
        if (on && v != 0) begin
            for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] && m_note[i] == n) t = i;
            for (int i = 0; i < NV; i++) if (t < 0 && !m_gate[i]) t = i;
            if (t < 0) begin
                t = 0;
                for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
                m_steal = 1;
            end
            for (int i = 0; i < NV; i++) if (i != t && m_gate[i] && m_age[i] < AMAX) m_age[i]++;
            m_gate[t] = 1; m_sus[t] = 0; m_note[t] = n; m_vel[t] = v; m_age[t] = 0;
        end else begin
            for (int i = 0; i < NV; i++) if (t < 0 && m_gate[i] && !m_sus[i] && m_note[i] == n) t = i;
            if (t >= 0) begin
                if (sustain) m_sus[t] = 1;
                else m_gate[t] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        m_steal = 0;
    endtask

    // pan >= 0 pulses the panic input on that scan cycle
    task automatic send(input bit on, input int n, input int v, input int pan);
        int k = 0;
        ev_valid = 1; ev_on = on; ev_note = NW'(n); ev_vel = VW'(v);
        while (!ev_ready && k < 8) begin
            step();
            k++;
        end
        check("accept_ready", 64'(ev_ready), 1);
        if (!ev_ready) begin
            ev_valid = 0;
            return;
        end
        step();
        ev_valid = 0;
        check("busy_ready", 64'(ev_ready), 0);
        for (int i = 0; i < NV; i++) begin
            if (i == pan) all_off = 1;
            check("scan_hold", 64'(gate), e_gate());
            step();
            all_off = 0;
        end
        step();
        m_event(on, n, v);
        check_all("commit");
        check("ready_after", 64'(ev_ready), (pan >= 0) ? 0 : 1);
        if (pan >= 0) begin
            step();
            m_panic();
            check_all("late_panic");
        end
    endtask

    task automatic set_sus(input bit b);
        bit prev = sustain;
        sustain = b;
        step();
        if (prev && !b) m_release();
        check_all("sustain");
    endtask

    task automatic panic_idle();
        all_off = 1;
        @(posedge clk or negedge clk);
        check("panic_ready", 64'(ev_ready), 0);
        step();
        all_off = 0;
        m_panic();
        check_all("panic");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1; ev_valid = 0; ev_on = 0; ev_note = '0; ev_vel = '0; sustain = 0; all_off = 0;
        m_reset();
        @(negedge clk);
        repeat (3) step();
        check_all("reset");
        check("reset_ready", 64'(ev_ready), 0);
        rst = 0;
        #1;
        check("ready_after_reset", 64'(ev_ready), 1);
        @(negedge clk);

        send(1, 60, 100, -1);
        check("first_note", 64'(notes[NW-1:0]), 60);
        send(1, 62, 90, -1);
        send(1, 64, 80, -1);
        send(1, 65, 70, -1);
        send(1, 67, 60, -1);
        check("steal_pulse", 64'(steal), 1);
        check("steal_v0", 64'(notes[NW-1:0]), 67);
        step();
        check_all("steal_drop");
        panic_idle();
        send(0, 72, 0, -1);

        send(1, 60, 100, -1);
        send(1, 60, 50, -1);
        check("retrig_vel", 64'(vels[VW-1:0]), 50);
        panic_idle();

        set_sus(1);
        send(1, 60, 100, -1);
        send(0, 60, 0, -1);
        sustain = 0;
        ev_valid = 1; ev_on = 1; ev_note = 7'd70; ev_vel = 7'd5;
        #1;
        check("sus_fall_block", 64'(ev_ready), 0);
        step();
        ev_valid = 0;
        m_release();
        check_all("sus_release");
        check("release_note", 64'(notes[NW-1:0]), 60);

        send(1, 64, 30, 2);

        send(1, 61, 40, -1);
        ev_valid = 1; ev_on = 1; ev_note = 7'd66; ev_vel = 7'd9;
        step();
        ev_valid = 0;
        step();
        step();
        rst = 1;
        step();
        m_reset();
        check_all("reset_scan");
        check("reset_scan_ready", 64'(ev_ready), 0);
        rst = 0;
        #1;
        check("ready_post_reset", 64'(ev_ready), 1);
        @(negedge clk);
        repeat (NV + 2) step();
        check_all("discarded");

        for (int it = 0; it < 200; it++) begin
            int r = $urandom_range(0, 9);
            int n = 60 + $urandom_range(0, 7);
            int v = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
            if (r <= 4) send(1, n, v, -1);
            else if (r <= 6) send(0, n, 0, -1);
            else if (r == 7) set_sus(!sustain);
            else if (r == 8) panic_idle();
            else send(1, n, v, $urandom_range(0, NV - 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
